// File: rtl/uart_alu_pkg.sv
// Shared constants for the UART ALU sequencer: sync byte, opcode map and
// the sequencer FSM encoding.
package uart_alu_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_NOR = 6'b100111;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_GET_A     = 3'd1,
        ST_GET_B     = 3'd2,
        ST_GET_OP    = 3'd3,
        ST_EXEC      = 3'd4,
        ST_SEND_RES  = 3'd5,
        ST_SEND_STAT = 3'd6
    } seq_state_t;

    function automatic logic op_is_valid(input logic [5:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_NOR, OP_SRA, OP_SRL: op_is_valid = 1'b1;
            default:                        op_is_valid = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/seq_timeout_counter.sv
// Idle-cycle counter: clear has priority, counts while enabled and saturates
// at TIMEOUT_CYCLES-1, where at_limit is raised.
module seq_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 1_000_000,
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic at_limit
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign at_limit = (cnt_q == LIMIT);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !at_limit) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_alu_sequencer.sv
// Frame sequencer between UART FIFOs and an external ALU: pulls SYNC,A,B,OP
// from RX, runs the ALU for one cycle and pushes RESULT then STATUS to TX.
module uart_alu_sequencer
    import uart_alu_pkg::*;
#(
    parameter int BUS_SIZE       = 8,
    parameter int OP_SIZE        = 6,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                clk,
    input  logic                i_reset,
    input  logic [BUS_SIZE-1:0] i_rx_data,
    input  logic                i_rx_empty,
    output logic                o_rx_rd,
    input  logic                i_tx_full,
    output logic                o_tx_wr,
    output logic [BUS_SIZE-1:0] o_tx_data,
    output logic [BUS_SIZE-1:0] o_alu_a,
    output logic [BUS_SIZE-1:0] o_alu_b,
    output logic [OP_SIZE-1:0]  o_alu_op,
    input  logic [BUS_SIZE-1:0] i_alu_result,
    output logic                o_busy,
    output logic                o_err_timeout
);

    seq_state_t          state_q, state_d;
    logic [BUS_SIZE-1:0] alu_a_q, alu_a_d;
    logic [BUS_SIZE-1:0] alu_b_q, alu_b_d;
    logic [OP_SIZE-1:0]  alu_op_q, alu_op_d;
    logic [BUS_SIZE-1:0] result_q, result_d;
    logic                invalid_q, invalid_d;
    logic                timeout_seen_q, timeout_seen_d;

    logic                rx_rd, tx_wr, err_to;
    logic                cnt_clr, cnt_en, at_limit;
    logic                op_valid;
    logic [31:0]         op_ext;
    logic [BUS_SIZE-1:0] status_byte;

    // Opcodes wider than the 6-bit map are only valid with zero upper bits.
    assign op_ext   = 32'(alu_op_q);
    assign op_valid = (op_ext[31:6] == '0) && op_is_valid(op_ext[5:0]);

    always_comb begin
        status_byte    = '0;
        status_byte[1] = timeout_seen_q;
        status_byte[0] = invalid_q;
    end

    seq_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (i_reset),
        .clr     (cnt_clr),
        .en      (cnt_en),
        .at_limit(at_limit)
    );

    always_comb begin
        state_d        = state_q;
        alu_a_d        = alu_a_q;
        alu_b_d        = alu_b_q;
        alu_op_d       = alu_op_q;
        result_d       = result_q;
        invalid_d      = invalid_q;
        timeout_seen_d = timeout_seen_q;
        rx_rd          = 1'b0;
        tx_wr          = 1'b0;
        err_to         = 1'b0;
        cnt_clr        = 1'b0;
        cnt_en         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_clr = 1'b1;
                if (!i_rx_empty) begin
                    rx_rd = 1'b1;
                    if (i_rx_data == BUS_SIZE'(SYNC_BYTE)) begin
                        state_d = ST_GET_A;
                    end
                end
            end
            ST_GET_A, ST_GET_B, ST_GET_OP: begin
                cnt_en = 1'b1;
                if (!i_rx_empty) begin
                    // A pop on the limit cycle beats the timeout.
                    rx_rd   = 1'b1;
                    cnt_clr = 1'b1;
                    case (state_q)
                        ST_GET_A: begin
                            alu_a_d = i_rx_data;
                            state_d = ST_GET_B;
                        end
                        ST_GET_B: begin
                            alu_b_d = i_rx_data;
                            state_d = ST_GET_OP;
                        end
                        default: begin
                            alu_op_d = OP_SIZE'(i_rx_data);
                            state_d  = ST_EXEC;
                        end
                    endcase
                end else if (at_limit) begin
                    err_to         = 1'b1;
                    timeout_seen_d = 1'b1;
                    cnt_clr        = 1'b1;
                    state_d        = ST_IDLE;
                end
            end
            ST_EXEC: begin
                cnt_clr   = 1'b1;
                invalid_d = !op_valid;
                result_d  = op_valid ? i_alu_result : '0;
                state_d   = ST_SEND_RES;
            end
            ST_SEND_RES: begin
                cnt_clr = 1'b1;
                if (!i_tx_full) begin
                    tx_wr   = 1'b1;
                    state_d = ST_SEND_STAT;
                end
            end
            ST_SEND_STAT: begin
                cnt_clr = 1'b1;
                if (!i_tx_full) begin
                    tx_wr          = 1'b1;
                    timeout_seen_d = 1'b0;
                    state_d        = ST_IDLE;
                end
            end
            default: begin
                cnt_clr = 1'b1;
                state_d = ST_IDLE;
            end
        endcase

        // Strobes must stay quiet while reset is held, even though IDLE pops.
        if (i_reset) begin
            rx_rd  = 1'b0;
            tx_wr  = 1'b0;
            err_to = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            state_q        <= ST_IDLE;
            alu_a_q        <= '0;
            alu_b_q        <= '0;
            alu_op_q       <= '0;
            result_q       <= '0;
            invalid_q      <= 1'b0;
            timeout_seen_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            alu_a_q        <= alu_a_d;
            alu_b_q        <= alu_b_d;
            alu_op_q       <= alu_op_d;
            result_q       <= result_d;
            invalid_q      <= invalid_d;
            timeout_seen_q <= timeout_seen_d;
        end
    end

    assign o_rx_rd       = rx_rd;
    assign o_tx_wr       = tx_wr;
    assign o_tx_data     = (state_q == ST_SEND_STAT) ? status_byte : result_q;
    assign o_alu_a       = alu_a_q;
    assign o_alu_b       = alu_b_q;
    assign o_alu_op      = alu_op_q;
    assign o_busy        = (state_q != ST_IDLE);
    assign o_err_timeout = err_to;

endmodule

// File: tb/tb_uart_alu_sequencer.sv
// Directed and randomized frames through FIFO models, checked against a
// frame-level reference of the expected TX byte stream.
module tb_uart_alu_sequencer;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       i_reset;
    logic [7:0] i_rx_data;
    logic       i_rx_empty;
    logic       o_rx_rd;
    logic       i_tx_full;
    logic       o_tx_wr;
    logic [7:0] o_tx_data;
    logic [7:0] o_alu_a, o_alu_b;
    logic [5:0] o_alu_op;
    logic [7:0] i_alu_result;
    logic       o_busy;
    logic       o_err_timeout;

    logic [7:0] rxq[$];
    logic [7:0] txq[$];
    int vectors = 0, errors = 0;
    int cyc = 0, last_pop = -1, err_cnt = 0, err_cyc = -1;
    bit tx_full_v = 1'b0, rand_full = 1'b0;

    localparam logic [5:0] VALID_OPS[8] = '{6'h20, 6'h22, 6'h24, 6'h25,
                                            6'h26, 6'h27, 6'h03, 6'h02};

    always #5 clk = ~clk;

    uart_alu_sequencer #(.BUS_SIZE(8), .OP_SIZE(6), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .i_reset(i_reset), .i_rx_data(i_rx_data), .i_rx_empty(i_rx_empty),
        .o_rx_rd(o_rx_rd), .i_tx_full(i_tx_full), .o_tx_wr(o_tx_wr), .o_tx_data(o_tx_data),
        .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_op(o_alu_op),
        .i_alu_result(i_alu_result), .o_busy(o_busy), .o_err_timeout(o_err_timeout)
    );

    // External ALU model; an undefined opcode yields junk the sequencer must mask.
    function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                           input logic [5:0] op);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            6'h27:   return ~(a | b);
            6'h03:   return 8'($signed(a) >>> b);
            6'h02:   return a >> b;
            default: return 8'h5A;
        endcase
    endfunction

    function automatic bit op_ok(input logic [5:0] op);
        foreach (VALID_OPS[i]) if (VALID_OPS[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    assign i_alu_result = alu_ref(o_alu_a, o_alu_b, o_alu_op);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        i_rx_empty = (rxq.size() == 0);
        i_rx_data  = (rxq.size() != 0) ? rxq[0] : 8'h00;
        i_tx_full  = rand_full ? 1'($urandom_range(0, 1)) : tx_full_v;
    endtask

    // One clock: observe strobes mid-cycle, commit FIFO effects after the edge.
    task automatic step();
        bit pop;
        @(negedge clk);
        pop = o_rx_rd;
        if (o_rx_rd) begin
            check("rd_when_empty", i_rx_empty, 0);
            last_pop = cyc;
        end
        if (o_tx_wr) begin
            check("wr_when_full", i_tx_full, 0);
            txq.push_back(o_tx_data);
        end
        if (o_err_timeout) begin
            err_cnt++;
            err_cyc = cyc;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (pop) rxq.delete(0);
        drive();
    endtask

    task automatic wait_tx(input int n);
        int b = 0;
        while (txq.size() < n && b < 400) begin
            step();
            b++;
        end
        repeat (3) step();
        check("tx_count", txq.size(), n);
    endtask

    // Reference: a frame yields RESULT (0 if opcode undefined) then STATUS.
    task automatic expect_resp(input string tag, input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] opb, input bit to_seen);
        logic [5:0] op;
        logic [7:0] res, st;
        op  = opb[5:0];
        res = op_ok(op) ? alu_ref(a, b, op) : 8'h00;
        st  = {6'b0, to_seen, !op_ok(op)};
        wait_tx(2);
        check({tag, "_result"}, (txq.size() > 0) ? 32'(txq[0]) : 32'hDEAD, 32'(res));
        check({tag, "_status"}, (txq.size() > 1) ? 32'(txq[1]) : 32'hDEAD, 32'(st));
        txq.delete();
    endtask

    task automatic frame(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] opb, input bit to_seen);
        rxq.push_back(8'hA5);
        rxq.push_back(a);
        rxq.push_back(b);
        rxq.push_back(opb);
        drive();
        expect_resp(tag, a, b, opb, to_seen);
    endtask

    initial begin
        int p, e0, b;
        logic [7:0] a, bb, ob, junk;

        // Reset with a byte waiting: no pop may occur while held.
        i_reset = 1'b1;
        rxq.push_back(8'h11);
        drive();
        @(negedge clk);
        check("rst_rx_rd", o_rx_rd, 0);
        check("rst_tx_wr", o_tx_wr, 0);
        check("rst_busy", o_busy, 0);
        check("rst_err", o_err_timeout, 0);
        check("rst_tx_data", o_tx_data, 0);
        check("rst_alu", {o_alu_a, o_alu_b, 2'b0, o_alu_op}, 0);
        @(posedge clk);
        #1;
        rxq.delete();
        i_reset = 1'b0;
        drive();

        // Basic ADD frame.
        frame("add", 8'h05, 8'h03, 8'h20, 1'b0);
        check("add_regs", {o_alu_a, o_alu_b, 2'b0, o_alu_op}, {8'h05, 8'h03, 8'h20});

        // Leading junk is dropped.
        rxq.push_back(8'h11);
        rxq.push_back(8'h22);
        frame("junk_and", 8'hF0, 8'h0F, 8'h24, 1'b0);
        check("junk_drained", rxq.size(), 0);

        // Undefined opcode.
        frame("inv", 8'h01, 8'h02, 8'h3F, 1'b0);

        // Timeout after A is received.
        err_cnt = 0;
        rxq.push_back(8'hA5);
        rxq.push_back(8'h07);
        drive();
        b = 0;
        while (err_cnt == 0 && b < 80) begin
            step();
            b++;
        end
        check("to_pulses", err_cnt, 1);
        check("to_cycle", err_cyc - last_pop, TO);
        check("to_busy", o_busy, 0);
        repeat (5) step();
        check("to_single", err_cnt, 1);
        frame("to_sticky", 8'h10, 8'h20, 8'h22, 1'b1);
        frame("to_cleared", 8'h10, 8'h20, 8'h26, 1'b0);

        // A byte arriving exactly on the limit cycle is taken, no timeout.
        e0 = err_cnt;
        p  = last_pop;
        rxq.push_back(8'hA5);
        drive();
        b = 0;
        while (last_pop == p && b < 20) begin
            step();
            b++;
        end
        p = last_pop;
        while (cyc < p + TO) step();
        rxq.push_back(8'h09);
        rxq.push_back(8'h04);
        rxq.push_back(8'h25);
        drive();
        expect_resp("limit_pop", 8'h09, 8'h04, 8'h25, 1'b0);
        check("limit_no_to", err_cnt, e0);

        // TX full during SEND_RES: no push until released, then exactly two.
        tx_full_v = 1'b1;
        rxq.push_back(8'hA5);
        rxq.push_back(8'h33);
        rxq.push_back(8'h44);
        rxq.push_back(8'h25);
        drive();
        repeat (16) step();
        check("full_no_wr", txq.size(), 0);
        check("full_busy", o_busy, 1);
        check("full_data", o_tx_data, 8'h77);
        tx_full_v = 1'b0;
        drive();
        expect_resp("full_rel", 8'h33, 8'h44, 8'h25, 1'b0);

        // Reset in GET_B drops the partial frame.
        rxq.push_back(8'hA5);
        rxq.push_back(8'h9A);
        drive();
        b = 0;
        while (rxq.size() != 0 && b < 20) begin
            step();
            b++;
        end
        check("getb_busy", o_busy, 1);
        i_reset = 1'b1;
        #1;
        check("mid_rst_busy", o_busy, 0);
        check("mid_rst_alu", {o_alu_a, o_alu_b, 2'b0, o_alu_op}, 0);
        check("mid_rst_tx", {o_tx_data, o_tx_wr, o_rx_rd, o_err_timeout}, 0);
        step();
        i_reset = 1'b0;
        drive();
        frame("post_rst", 8'hC8, 8'h02, 8'h03, 1'b0);

        // Randomized frames with junk and a toggling TX-full.
        rand_full = 1'b1;
        for (int n = 0; n < 24; n++) begin
            for (int j = 0; j < int'($urandom_range(0, 3)); j++) begin
                junk = 8'($urandom);
                if (junk == 8'hA5) junk = 8'h5A;
                rxq.push_back(junk);
            end
            a  = 8'($urandom);
            bb = 8'($urandom_range(0, 9));
            if ($urandom_range(0, 3) != 0) ob = {2'($urandom), VALID_OPS[$urandom_range(0, 7)]};
            else ob = 8'($urandom);
            frame("rand", a, bb, ob, 1'b0);
        end
        rand_full = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_alu_sequencer.md
UART_ALU_SEQUENCER -- requirements
Module: uart_alu_sequencer

Interface
REQ-001 Parameter BUS_SIZE, default 8: data width of the FIFO bytes, ALU operands and ALU result.
REQ-002 Parameter OP_SIZE, default 6: opcode width; the opcode is taken from the low OP_SIZE bits of the OP byte.
REQ-003 Parameter TIMEOUT_CYCLES, default 1_000_000: maximum idle cycles allowed between bytes of one frame.
REQ-004 clk  in  1  single system clock; all logic on rising edge.
REQ-005 i_reset  in  1  asynchronous, active-high reset.
REQ-006 i_rx_data  in  BUS_SIZE  RX FIFO head byte (first-word-fall-through); valid while i_rx_empty=0.
REQ-007 i_rx_empty  in  1  RX FIFO empty.
REQ-008 o_rx_rd  out  1  one-cycle pop strobe; the head byte is consumed in the same cycle.
REQ-009 i_tx_full  in  1  TX FIFO full.
REQ-010 o_tx_wr  out  1  one-cycle push strobe for o_tx_data.
REQ-011 o_tx_data  out  BUS_SIZE  byte pushed to the TX FIFO.
REQ-012 o_alu_a, o_alu_b  out  BUS_SIZE  registered ALU operands.
REQ-013 o_alu_op  out  OP_SIZE  registered ALU opcode.
REQ-014 i_alu_result  in  BUS_SIZE  combinational ALU result.
REQ-015 o_busy  out  1  high in every state except IDLE.
REQ-016 o_err_timeout  out  1  one-cycle pulse when a frame is aborted by timeout.

Function
REQ-017 Frame format: SYNC=0xA5, A, B, OP; response is two TX bytes: RESULT, then STATUS.
REQ-018 States: IDLE, GET_A, GET_B, GET_OP, EXEC, SEND_RES, SEND_STAT.
REQ-019 o_rx_rd is asserted only in IDLE, GET_A, GET_B and GET_OP, and only when i_rx_empty=0; it is never asserted when i_rx_empty=1.
REQ-020 In IDLE, every available byte is popped; 0xA5 moves the FSM to GET_A, and any other byte is discarded while the FSM stays in IDLE.
REQ-021 In GET_A, GET_B and GET_OP, a pop latches i_rx_data into o_alu_a, o_alu_b or o_alu_op respectively and advances to the next state; the GET_OP pop advances to EXEC.
REQ-022 EXEC lasts exactly one cycle: it latches i_alu_result into the result register and sets STATUS bit0 if the opcode is not in the package opcode list. It then moves to SEND_RES.
REQ-023 The valid opcodes are ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, NOR 100111, SRA 000011 and SRL 000010.
REQ-024 For an invalid opcode, the RESULT byte sent is 0x00.
REQ-025 In SEND_RES and SEND_STAT, o_tx_wr=1 for exactly one cycle, in the first cycle with i_tx_full=0. The FSM advances on that cycle. o_tx_data stays stable while waiting.
REQ-026 STATUS = {6'b0, timeout_seen, invalid_op}.
- timeout_seen is a sticky flag set by any timeout since the last STATUS byte sent.
- timeout_seen is cleared when the STATUS byte is pushed.
REQ-027 After SEND_STAT, the FSM returns to IDLE. Minimum latency from the OP pop to the RESULT push is 2 cycles.
REQ-028 Timeout counter:
- Cleared on every pop and on entry to GET_A.
- Increments each cycle in GET_A, GET_B and GET_OP.
- On reaching TIMEOUT_CYCLES-1 with no pop in that cycle: FSM goes to IDLE, o_err_timeout pulses, timeout_seen is set.
- A pop in the same cycle as the limit wins: no timeout.
REQ-029 No timeout applies in IDLE, EXEC or the SEND states; a full TX FIFO stalls the FSM indefinitely.
REQ-030 o_alu_a, o_alu_b and o_alu_op hold their values until overwritten by the next frame.

Reset
REQ-031 While i_reset=1, the FSM is IDLE regardless of the current state, including mid-frame or mid-send; any partially received frame is dropped.
REQ-032 Reset values: o_rx_rd=0, o_tx_wr=0, o_busy=0, o_err_timeout=0, o_tx_data=0, o_alu_a=0, o_alu_b=0, o_alu_op=0, result register=0, STATUS flags=0, timeout counter=0.

Structure
REQ-033 Package uart_alu_pkg holds the SYNC constant, opcode constants and the FSM state encoding (3 bits). The ALU and the UART top also use this package.
REQ-034 One sub-module, seq_timeout_counter, holds the clear/enable/limit counter; it is parameterised by TIMEOUT_CYCLES and its width is derived as clog2 of TIMEOUT_CYCLES.

Verification
REQ-035 RX sequence A5,05,03,20; ALU returns 0x08 → TX receives 08 then 00; o_alu_a=05, o_alu_b=03, o_alu_op=100000.
REQ-036 RX sequence 11,22,A5,F0,0F,24 → 11 and 22 are popped and dropped; TX receives RESULT (ALU AND = 00) then 00.
REQ-037 RX sequence A5,01,02,3F → TX receives 00 then 01 (invalid opcode).
REQ-038 With TIMEOUT_CYCLES=16: send A5,07, then stall → o_err_timeout pulses once in the 16th cycle without a pop and o_busy=0. A subsequent full frame returns STATUS=02, and the frame after that returns STATUS=00.
REQ-039 i_tx_full=1 held 10 cycles during SEND_RES → o_tx_wr stays 0 throughout. After release, exactly one push each for RESULT and STATUS with no duplicates.
REQ-040 i_reset pulsed in GET_B → next cycle: IDLE, all outputs at reset values. A following valid frame is processed correctly.
